imm_gen_pipe: RTL and testbench

- Registered, handshaked immediate generator for the ID stage of the pipelined RV processor.
- Decodes the full 7-bit opcode and covers every RISC-V immediate format: I, S, B, U, J and shift-amount.
- Sign-extends the immediate to XLEN and also emits a precomputed PC-relative target (pc + imm).
- Sits between the IF/ID register and the ID/EX register, with valid/ready backpressure and flush support.

---
 rtl/imm_gen_pipe.sv | 151 +++++++++++++++
 tb/tb_imm_gen_pipe.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for the ID stage: decodes every RV immediate
// format, sign-extends to XLEN and precomputes pc + imm behind a one-entry valid/ready stage.
module imm_gen_pipe #(
    parameter int XLEN    = 64,
    parameter int SHAMT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc
);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Handshake: a transfer happens on an edge where valid && ready are both high.
    // in_ready is combinational so a draining entry can be replaced without a bubble.
    logic            r_out_valid;
    logic [XLEN-1:0] r_out_imm;
    logic [2:0]      r_out_fmt;
    logic [XLEN-1:0] r_out_target;
    logic [XLEN-1:0] r_out_pc;

    logic [6:0]         w_opcode;
    logic               w_is_shift;
    logic signed [11:0] w_imm_i;
    logic signed [11:0] w_imm_s;
    logic signed [12:0] w_imm_b;
    logic signed [31:0] w_imm_u;
    logic signed [20:0] w_imm_j;
    logic [XLEN-1:0]    w_imm;
    logic [2:0]         w_fmt;
    logic [XLEN-1:0]    w_target;
    logic               w_accept;

    assign w_opcode   = in_inst[6:0];
    assign w_is_shift = (in_inst[13:12] == 2'b01);
    assign w_imm_i    = in_inst[31:20];
    assign w_imm_s    = {in_inst[31:25], in_inst[11:7]};
    assign w_imm_b    = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign w_imm_u    = {in_inst[31:12], 12'b0};
    assign w_imm_j    = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    // Signed fields are widened with size casts, which sign-extend to XLEN.
    always_comb begin
        w_fmt = FMT_NONE;
        w_imm = '0;
        case (w_opcode)
            OP_LOAD, OP_JALR: begin
                w_fmt = FMT_I;
                w_imm = XLEN'(w_imm_i);
            end
            OP_IMM: begin
                if (w_is_shift) begin
                    w_fmt = FMT_SHAMT;
                    w_imm = XLEN'(in_inst[20 +: SHAMT_W]);
                end else begin
                    w_fmt = FMT_I;
                    w_imm = XLEN'(w_imm_i);
                end
            end
            OP_IMM32: begin
                if (XLEN == 64) begin
                    if (w_is_shift) begin
                        w_fmt = FMT_SHAMT;
                        w_imm = XLEN'(in_inst[24:20]);
                    end else begin
                        w_fmt = FMT_I;
                        w_imm = XLEN'(w_imm_i);
                    end
                end
            end
            OP_STORE: begin
                w_fmt = FMT_S;
                w_imm = XLEN'(w_imm_s);
            end
            OP_BRANCH: begin
                w_fmt = FMT_B;
                w_imm = XLEN'(w_imm_b);
            end
            OP_LUI, OP_AUIPC: begin
                w_fmt = FMT_U;
                w_imm = XLEN'(w_imm_u);
            end
            OP_JAL: begin
                w_fmt = FMT_J;
                w_imm = XLEN'(w_imm_j);
            end
            default: begin
                w_fmt = FMT_NONE;
                w_imm = '0;
            end
        endcase
    end

    assign w_target = in_pc + w_imm;
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Flush only drops the valid bit; data registers keep their last contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_imm    <= '0;
            r_out_fmt    <= FMT_NONE;
            r_out_target <= '0;
            r_out_pc     <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_imm    <= w_imm;
            r_out_fmt    <= w_fmt;
            r_out_target <= w_target;
            r_out_pc     <= in_pc;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_imm    = r_out_imm;
    assign out_fmt    = r_out_fmt;
    assign out_target = r_out_target;
    assign out_pc     = r_out_pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 64-bit and a 32-bit instance share clock
// and reset; expected results are queued on drive and compared on output.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;

    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc, out_imm, out_target, out_pc;
    logic [2:0]  out_fmt;

    logic        v32, rdy32_in, flush32, ov32, ordy32;
    logic [31:0] inst32, pc32, imm32, tgt32, opc32;
    logic [2:0]  fmt32;

    typedef struct packed {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [63:0] pc;
        logic [2:0]  fmt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .SHAMT_W(6)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_target(out_target), .out_pc(out_pc)
    );

    imm_gen_pipe #(.XLEN(32), .SHAMT_W(5)) dut32 (
        .clk(clk), .reset(reset),
        .in_valid(v32), .in_ready(rdy32_in), .in_inst(inst32), .in_pc(pc32),
        .flush(flush32),
        .out_valid(ov32), .out_ready(ordy32), .out_imm(imm32),
        .out_fmt(fmt32), .out_target(tgt32), .out_pc(opc32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, need %h", tag, obs, exp);
        end
    endtask

    task automatic pop_cmp(input bit is32, input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s: got empty queue, need an entry", tag);
        end else begin
            e = exp_q.pop_front();
            if (is32) begin
                chk({tag, "_valid"}, 64'(ov32), 64'd1);
                chk({tag, "_imm"},   {32'b0, imm32}, e.imm);
                chk({tag, "_fmt"},   64'(fmt32), 64'(e.fmt));
                chk({tag, "_tgt"},   {32'b0, tgt32}, e.tgt);
                chk({tag, "_pc"},    {32'b0, opc32}, e.pc);
            end else begin
                chk({tag, "_valid"}, 64'(out_valid), 64'd1);
                chk({tag, "_imm"},   out_imm, e.imm);
                chk({tag, "_fmt"},   64'(out_fmt), 64'(e.fmt));
                chk({tag, "_tgt"},   out_target, e.tgt);
                chk({tag, "_pc"},    out_pc, e.pc);
            end
        end
    endtask

    task automatic send(input bit is32, input string tag, input logic [31:0] inst,
                        input logic [63:0] pc, input logic [63:0] imm,
                        input logic [63:0] tgt, input logic [2:0] fmt, input logic ordy);
        if (is32) begin
            v32 = 1'b1; inst32 = inst; pc32 = pc[31:0]; ordy32 = ordy;
        end else begin
            in_valid = 1'b1; in_inst = inst; in_pc = pc; out_ready = ordy;
        end
        exp_q.push_back('{imm, tgt, pc, fmt});
        @(posedge clk); #1;
        in_valid = 1'b0;
        v32 = 1'b0;
        pop_cmp(is32, tag);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; flush32 = 1'b0;
        in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
        v32 = 1'b0; inst32 = '0; pc32 = '0; ordy32 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_imm", out_imm, 64'd0);
        chk("rst_fmt", 64'(out_fmt), 64'd0);
        chk("rst_tgt", out_target, 64'd0);
        chk("rst_pc", out_pc, 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst32_valid", 64'(ov32), 64'd0);
        reset = 1'b0;

        // one instruction per format, back to back
        send(0, "addi", 32'hFFF00093, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b1);
        send(0, "sd", 32'h0020B423, 64'h200, 64'h8, 64'h208, 3'd2, 1'b1);
        send(0, "beq", 32'hFE000EE3, 64'h100, 64'hFFFFFFFFFFFFFFFC, 64'hFC, 3'd3, 1'b1);
        send(0, "lui", 32'h800002B7, 64'h40, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000040, 3'd4, 1'b1);
        send(0, "jal", 32'h001000EF, 64'h1000, 64'h800, 64'h1800, 3'd5, 1'b1);
        send(0, "srai", 32'h4030D093, 64'h10, 64'h3, 64'h13, 3'd6, 1'b1);
        send(0, "add", 32'h00000033, 64'h2000, 64'h0, 64'h2000, 3'd0, 1'b1);
        send(0, "slli63", 32'h03F01093, 64'h0, 64'd63, 64'd63, 3'd6, 1'b1);
        send(0, "slliw31", 32'h03F0109B, 64'h0, 64'd31, 64'd31, 3'd6, 1'b1);
        send(0, "addiw", 32'hFFF0009B, 64'h20, 64'hFFFFFFFFFFFFFFFF, 64'h1F, 3'd1, 1'b1);
        send(0, "ld", 32'h80003083, 64'h1000, 64'hFFFFFFFFFFFFF800, 64'h800, 3'd1, 1'b1);

        // idle cycle drains the entry
        @(posedge clk); #1;
        chk("drain_valid", 64'(out_valid), 64'd0);

        // stall: entry A held for three cycles while B waits
        send(0, "stA", 32'h00500113, 64'h300, 64'h5, 64'h305, 3'd1, 1'b0);
        in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 64'h400;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_imm", out_imm, 64'h5);
            chk("stall_fmt", 64'(out_fmt), 64'd1);
            chk("stall_tgt", out_target, 64'h305);
            chk("stall_pc", out_pc, 64'h300);
        end
        out_ready = 1'b1;
        #1;
        chk("release_ready", 64'(in_ready), 64'd1);
        exp_q.push_back('{64'hFFFFFFFFFFFFFFFF, 64'h3FF, 64'h400, 3'd1});
        @(posedge clk); #1;
        in_valid = 1'b0;
        pop_cmp(0, "stB");

        // flush with a simultaneous accept: C must never appear
        in_valid = 1'b1; in_inst = 32'h001000EF; in_pc = 64'h0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_hold_imm", out_imm, 64'hFFFFFFFFFFFFFFFF);
        chk("flush_hold_pc", out_pc, 64'h400);
        @(posedge clk); #1;
        chk("flush_valid2", 64'(out_valid), 64'd0);
        chk("flush_q_empty", 64'(exp_q.size()), 64'd0);

        // reset in the middle of a stall
        send(0, "rsD", 32'h0020B423, 64'h200, 64'h8, 64'h208, 3'd2, 1'b0);
        @(posedge clk); #1;
        chk("rsD_stall_imm", out_imm, 64'h8);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_imm", out_imm, 64'd0);
        chk("midrst_fmt", 64'(out_fmt), 64'd0);
        chk("midrst_tgt", out_target, 64'd0);
        chk("midrst_pc", out_pc, 64'd0);

        // 32-bit instance
        send(1, "x32_addi", 32'hFFF00093, 64'h0, 64'hFFFFFFFF, 64'hFFFFFFFF, 3'd1, 1'b1);
        send(1, "x32_opimm32", 32'hFFF0009B, 64'h20, 64'h0, 64'h20, 3'd0, 1'b1);
        send(1, "x32_srai", 32'h4030D093, 64'h10, 64'h3, 64'h13, 3'd6, 1'b1);
        send(1, "x32_lui", 32'h800002B7, 64'h40, 64'h80000000, 64'h80000040, 3'd4, 1'b1);

        @(posedge clk); #1;
        chk("end_q_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
